// File: rtl/baud_tick_gen_if.sv
// Control and strobe bundle between a UART and its baud tick generator.
// The generator attaches through the slave modport; the UART logic attaches through the master modport.
interface baud_tick_gen_if #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4,
  parameter int OSR    = 16
);
  logic                    en;
  logic                    restart;
  logic [DIV_W-1:0]        div_int;
  logic [FRAC_W-1:0]       div_frac;
  logic                    div_load;
  logic                    div_pend;
  logic                    div_err;
  logic                    os_tick;
  logic                    bit_tick;
  logic                    mid_tick;
  logic [$clog2(OSR)-1:0]  os_idx;

  modport master (
    output en, restart, div_int, div_frac, div_load,
    input  div_pend, div_err, os_tick, bit_tick, mid_tick, os_idx
  );

  modport slave (
    input  en, restart, div_int, div_frac, div_load,
    output div_pend, div_err, os_tick, bit_tick, mid_tick, os_idx
  );
endinterface

// File: rtl/baud_tick_gen.sv
// Fractional baud-rate generator: oversample tick plus bit-boundary and bit-centre strobes,
// with a run-time reloadable divisor and receiver-driven phase re-alignment.
module baud_tick_gen #(
  parameter int                 DIV_W          = 16,
  parameter int                 FRAC_W         = 4,
  parameter int                 OSR            = 16,
  parameter logic [DIV_W-1:0]   RESET_DIV_INT  = 16'd27,
  parameter logic [FRAC_W-1:0]  RESET_DIV_FRAC = 4'd2
) (
  input  logic              clk,
  input  logic              rst,
  baud_tick_gen_if.slave    bus
);
  localparam int                IDX_W    = $clog2(OSR);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(OSR - 1);
  localparam logic [IDX_W-1:0]  IDX_MID  = IDX_W'(OSR / 2 - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W:0]    CNT_ONE  = {{DIV_W{1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0]  MIN_DIV  = {{(DIV_W-2){1'b0}}, 2'b10};

  logic [DIV_W:0]       cnt_r;
  logic [FRAC_W-1:0]    acc_r;
  logic                 extra_r;
  logic [IDX_W-1:0]     os_idx_r;
  logic [DIV_W-1:0]     a_int_r;
  logic [FRAC_W-1:0]    a_frac_r;
  logic [DIV_W-1:0]     p_int_r;
  logic [FRAC_W-1:0]    p_frac_r;
  logic                 div_pend_r;
  logic                 div_err_r;
  logic                 os_tick_r;
  logic                 bit_tick_r;
  logic                 mid_tick_r;

  logic [DIV_W:0]       term_s;
  logic                 wrap_s;
  logic                 load_ok_s;
  logic                 load_bad_s;
  logic [FRAC_W:0]      acc_sum_s;
  logic                 apply_s;
  logic [IDX_W-1:0]     idx_next_s;

  // Terminal count, accumulator sum and load/apply decisions for the current cycle.
  always_comb begin
    term_s     = {1'b0, a_int_r} - CNT_ONE + {{DIV_W{1'b0}}, extra_r};
    wrap_s     = bus.en && (cnt_r == term_s);
    load_ok_s  = bus.div_load && (bus.div_int >= MIN_DIV);
    load_bad_s = bus.div_load && (bus.div_int < MIN_DIV);
    acc_sum_s  = {1'b0, acc_r} + {1'b0, a_frac_r};
    // Outside restart, a pending divisor is taken at a wrap or while counting is paused.
    apply_s    = div_pend_r && (wrap_s || !bus.en);
    if (os_idx_r == IDX_LAST) begin
      idx_next_s = {IDX_W{1'b0}};
    end else begin
      idx_next_s = os_idx_r + IDX_ONE;
    end
  end

  // Period counter, fraction accumulator, strobes and divisor hand-over.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r      <= {(DIV_W+1){1'b0}};
      acc_r      <= {FRAC_W{1'b0}};
      extra_r    <= 1'b0;
      os_idx_r   <= {IDX_W{1'b0}};
      a_int_r    <= RESET_DIV_INT;
      a_frac_r   <= RESET_DIV_FRAC;
      p_int_r    <= {DIV_W{1'b0}};
      p_frac_r   <= {FRAC_W{1'b0}};
      div_pend_r <= 1'b0;
      div_err_r  <= 1'b0;
      os_tick_r  <= 1'b0;
      bit_tick_r <= 1'b0;
      mid_tick_r <= 1'b0;
    end else begin
      div_err_r <= load_bad_s;
      if (bus.restart) begin
        cnt_r      <= {(DIV_W+1){1'b0}};
        acc_r      <= {FRAC_W{1'b0}};
        extra_r    <= 1'b0;
        os_idx_r   <= {IDX_W{1'b0}};
        os_tick_r  <= 1'b0;
        bit_tick_r <= 1'b0;
        mid_tick_r <= 1'b0;
        div_pend_r <= 1'b0;
        // A load arriving together with restart wins over an older pending value.
        if (load_ok_s) begin
          a_int_r  <= bus.div_int;
          a_frac_r <= bus.div_frac;
          p_int_r  <= bus.div_int;
          p_frac_r <= bus.div_frac;
        end else if (div_pend_r) begin
          a_int_r  <= p_int_r;
          a_frac_r <= p_frac_r;
        end
      end else begin
        if (wrap_s) begin
          cnt_r      <= {(DIV_W+1){1'b0}};
          os_tick_r  <= 1'b1;
          bit_tick_r <= (os_idx_r == IDX_LAST);
          mid_tick_r <= (os_idx_r == IDX_MID);
          os_idx_r   <= idx_next_s;
        end else begin
          if (bus.en) begin
            cnt_r <= cnt_r + CNT_ONE;
          end
          os_tick_r  <= 1'b0;
          bit_tick_r <= 1'b0;
          mid_tick_r <= 1'b0;
        end
        if (apply_s) begin
          acc_r    <= {FRAC_W{1'b0}};
          extra_r  <= 1'b0;
          a_int_r  <= p_int_r;
          a_frac_r <= p_frac_r;
        end else if (wrap_s) begin
          {extra_r, acc_r} <= acc_sum_s;
        end
        if (load_ok_s) begin
          p_int_r    <= bus.div_int;
          p_frac_r   <= bus.div_frac;
          div_pend_r <= 1'b1;
        end else if (apply_s) begin
          div_pend_r <= 1'b0;
        end
      end
    end
  end

  assign bus.div_pend = div_pend_r;
  assign bus.div_err  = div_err_r;
  assign bus.os_tick  = os_tick_r;
  assign bus.bit_tick = bit_tick_r;
  assign bus.mid_tick = mid_tick_r;
  assign bus.os_idx   = os_idx_r;
endmodule

// File: tb/tb_baud_tick_gen.sv
// Scoreboard bench for baud_tick_gen: directed phases queue the hand-computed tick edges,
// and a negedge monitor pops and compares them whenever a strobe appears.
module tb_baud_tick_gen;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   tick_n = 0;

  typedef struct {
    int         edge_n;
    logic       bt;
    logic       mt;
    logic [3:0] idx;
  } tick_t;

  tick_t exp_q[$];

  baud_tick_gen_if bus ();

  baud_tick_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Tick number k since restart/reset: index k mod 16, boundary at 0, centre at 8.
  task automatic exp_tick(input int e);
    tick_t t;
    tick_n++;
    t.edge_n = e;
    t.idx    = 4'(tick_n % 16);
    t.bt     = (tick_n % 16) == 0;
    t.mt     = (tick_n % 16) == 8;
    exp_q.push_back(t);
  endtask

  task automatic wait_to(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_os_tick"}, int'(bus.os_tick), 0);
    check({tag, "_bit_tick"}, int'(bus.bit_tick), 0);
    check({tag, "_mid_tick"}, int'(bus.mid_tick), 0);
    check({tag, "_div_pend"}, int'(bus.div_pend), 0);
    check({tag, "_div_err"}, int'(bus.div_err), 0);
    check({tag, "_os_idx"}, int'(bus.os_idx), 0);
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    tick_t t;
    if (bus.os_tick || bus.bit_tick || bus.mid_tick) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_tick: strobe at edge %0d, none expected", cyc);
      end else begin
        t = exp_q.pop_front();
        check("tick_edge", cyc, t.edge_n);
        check("os_tick", int'(bus.os_tick), 1);
        check("bit_tick", int'(bus.bit_tick), int'(t.bt));
        check("mid_tick", int'(bus.mid_tick), int'(t.mt));
        check("os_idx", int'(bus.os_idx), int'(t.idx));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int c0;
    int t_end;
    bus.en       = 1'b1;
    bus.restart  = 1'b0;
    bus.div_int  = 16'd0;
    bus.div_frac = 4'd0;
    bus.div_load = 1'b0;

    // Reset defaults, then 27+2/16: the 9th and 17th periods stretch to 28.
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    c0 = cyc;
    e = c0;
    for (int k = 1; k <= 17; k++) begin
      e += ((k == 9) || (k == 17)) ? 28 : 27;
      exp_tick(e);
    end
    wait_to(e);

    // Integer load mid-period: old 27-cycle period finishes, then spacing 4.
    t_end = e;
    wait_to(t_end + 10);
    bus.div_int  = 16'd4;
    bus.div_frac = 4'd0;
    bus.div_load = 1'b1;
    e = t_end + 27;
    exp_tick(e);
    for (int k = 0; k < 16; k++) begin
      e += 4;
      exp_tick(e);
    end
    wait_to(t_end + 11);
    bus.div_load = 1'b0;
    check("pend_set", int'(bus.div_pend), 1);
    wait_to(t_end + 26);
    check("pend_hold", int'(bus.div_pend), 1);
    wait_to(t_end + 27);
    check("pend_clear_wrap", int'(bus.div_pend), 0);
    wait_to(e);

    // Fractional 5+8/16 applied by restart: periods 5,5,6,5,6,...
    t_end = e;
    wait_to(t_end + 1);
    bus.div_int  = 16'd5;
    bus.div_frac = 4'd8;
    bus.div_load = 1'b1;
    wait_to(t_end + 2);
    bus.div_load = 1'b0;
    check("pend_frac", int'(bus.div_pend), 1);
    bus.restart = 1'b1;
    tick_n = 0;
    e = t_end + 3;
    for (int k = 1; k <= 41; k++) begin
      e += (k == 1) ? 5 : ((k % 2 == 1) ? 6 : 5);
      exp_tick(e);
    end
    wait_to(t_end + 3);
    bus.restart = 1'b0;
    check("pend_clear_restart", int'(bus.div_pend), 0);
    wait_to(e);

    // Re-alignment with os_idx at 9.
    t_end = e;
    wait_to(t_end + 1);
    check("idx_before_restart", int'(bus.os_idx), 9);
    bus.restart = 1'b1;
    wait_to(t_end + 2);
    bus.restart = 1'b0;
    check("idx_after_restart", int'(bus.os_idx), 0);
    check("no_tick_on_restart", int'(bus.os_tick), 0);
    tick_n = 0;
    e = t_end + 2;
    for (int k = 1; k <= 9; k++) begin
      e += (k == 1) ? 5 : ((k % 2 == 1) ? 6 : 5);
      exp_tick(e);
    end
    wait_to(e);

    // Rejected load leaves the rate alone.
    t_end = e;
    wait_to(t_end + 1);
    bus.div_int  = 16'd1;
    bus.div_frac = 4'd3;
    bus.div_load = 1'b1;
    e = t_end + 5;
    exp_tick(e);
    wait_to(t_end + 2);
    bus.div_load = 1'b0;
    check("err_pulse", int'(bus.div_err), 1);
    check("err_no_pend", int'(bus.div_pend), 0);
    wait_to(t_end + 3);
    check("err_one_cycle", int'(bus.div_err), 0);
    wait_to(e);

    // Enable gating: 10 frozen edges inside a 6-cycle period.
    t_end = e;
    wait_to(t_end + 2);
    bus.en = 1'b0;
    e = t_end + 16;
    exp_tick(e);
    e += 5;
    exp_tick(e);
    wait_to(t_end + 12);
    bus.en = 1'b1;
    wait_to(e);

    // Asynchronous reset with a pending load discards it.
    t_end = e;
    wait_to(t_end + 1);
    bus.div_int  = 16'd4;
    bus.div_frac = 4'd0;
    bus.div_load = 1'b1;
    wait_to(t_end + 2);
    bus.div_load = 1'b0;
    check("pend_before_rst", int'(bus.div_pend), 1);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b1;
    tick_n = 0;
    c0 = cyc;
    e = c0 + 27;
    exp_tick(e);
    e += 27;
    exp_tick(e);
    wait_to(e + 5);

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
